// File: rtl/exu_issue_ctrl.sv
// exu_issue_ctrl: issue/sequencing controller wrapped around the combinational ALU.
// Accepts one decoded op, holds it on the ALU inputs for LATENCY cycles, captures
// the result and presents it to writeback until accepted. Counts retired ops and
// tags ops whose mode word selects more than one ALU operation.
module exu_issue_ctrl #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    // decode side
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    input  logic [31:0] in_imm,
    input  logic [10:0] in_mode,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    // ALU side
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [31:0] alu_imm,
    output logic [10:0] alu_mode,
    input  logic [31:0] alu_result,
    // writeback side
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_illegal,
    // status
    output logic        busy,
    output logic [31:0] retired_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    // Everything that travels with an op from accept to result capture.
    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] imm;
        logic [10:0] mode;
        logic [4:0]  rd;
        logic        wen;
        logic        illegal;
    } op_t;

    // Counter value on the edge that captures the ALU result.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    op_t              held;
    op_t              new_op;
    logic [9:0]       op_sel;
    logic             accept;
    logic             retire;

    // Op-select field must be zero (add) or one-hot; clearing the lowest set bit
    // leaves something behind exactly when two or more bits are set.
    assign op_sel = in_mode[10:1];

    assign new_op = '{
        src1:    in_src1,
        src2:    in_src2,
        imm:     in_imm,
        mode:    in_mode,
        rd:      in_rd,
        wen:     in_wen,
        illegal: |(op_sel & (op_sel - 10'd1))
    };

    // Ready only depends on our own state plus flush/out_ready, never on in_valid,
    // so there is no combinational loop back to decode.
    assign in_ready = rst_n & ~flush &
                      ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign retire   = (state == DONE) & out_valid & out_ready & ~flush;
    assign busy     = (state != IDLE);

    // ALU sees only held values so decode can change its outputs freely.
    assign alu_src1 = held.src1;
    assign alu_src2 = held.src2;
    assign alu_imm  = held.imm;
    assign alu_mode = held.mode;

    // Sequencer: accept -> execute for LATENCY cycles -> hold result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            held        <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
            out_illegal <= 1'b0;
            retired_cnt <= '0;
        end else if (flush) begin
            // Drop whatever is in flight; holding registers keep their contents.
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (retire) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if (accept) begin
                // Covers both IDLE accept and back-to-back accept from DONE.
                held      <= new_op;
                cnt       <= '0;
                out_valid <= 1'b0;
                state     <= EXEC;
            end else begin
                case (state)
                    EXEC: begin
                        if (cnt == CNT_LAST) begin
                            out_data    <= alu_result;
                            out_rd      <= held.rd;
                            out_wen     <= held.wen;
                            out_illegal <= held.illegal;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/exu_issue_ctrl.md
Name: exu_issue_ctrl

Overview:
- Multi-cycle issue/sequencing controller wrapped around the combinational execute unit (ALU).
- Accepts one decoded operation from IDU over a valid/ready handshake and latches the operands, mode and destination.
- Drives the ALU from held registers, waits LATENCY cycles, captures the result, and holds it for WBU until accepted.
- Also flags malformed mode words and counts retired operations.

Parameters:
- LATENCY, 1, execute cycles between accept and result capture; legal range 1..15.
- CNT_W, 4, width of the internal latency counter; must hold LATENCY-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard any in-flight or held op.
- in_valid  in  1  IDU has an op.
- in_ready  out  1  controller can accept an op this cycle.
- in_src1  in  32  GPR read data 1.
- in_src2  in  32  GPR read data 2.
- in_imm  in  32  immediate.
- in_mode  in  11  ALU mode word. Bit0 selects imm instead of src2; bits[10:1] are one-hot op select or all-zero (add).
- in_rd  in  5  destination register.
- in_wen  in  1  writeback enable.
- alu_src1  out  32  held operand to ALU.
- alu_src2  out  32  held operand to ALU.
- alu_imm  out  32  held immediate to ALU.
- alu_mode  out  11  held mode to ALU.
- alu_result  in  32  ALU combinational result.
- out_valid  out  1  result held for WBU.
- out_ready  in  1  WBU accepts.
- out_data  out  32  captured result.
- out_rd  out  5  held destination.
- out_wen  out  1  held writeback enable.
- out_illegal  out  1  held op had more than one bit set in mode[10:1].
- busy  out  1  state != IDLE.
- retired_cnt  out  32  count of ops accepted by WBU.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE; counter=0; out_valid=0; out_data=0; out_rd=0; out_wen=0; out_illegal=0; retired_cnt=0.
  - All alu_* holding registers cleared to 0.
  - in_ready is forced 0 while rst_n is low.
- States: IDLE, EXEC, DONE.
- in_ready = rst_n & ~flush & (state==IDLE | (state==DONE & out_ready)).
- IDLE:
  - in_valid & in_ready: latch src1, src2, imm, mode, rd, wen into holding registers; counter=0; go EXEC.
  - Illegal flag is computed at accept and held with the op.
- EXEC:
  - alu_* outputs are stable from holding registers.
  - Counter increments each cycle.
  - At the edge where counter==LATENCY-1: out_data<=alu_result; out_rd/out_wen/out_illegal<=held values; out_valid<=1; go DONE.
- Latency: accept at edge t0, out_valid high starting the cycle after edge t0+LATENCY.
  - LATENCY=1: out_valid is visible one cycle after accept.
- DONE:
  - out_valid stays 1 and all out_* are stable until out_valid & out_ready.
  - On that edge retired_cnt increments, wrapping 0xFFFFFFFF->0.
  - If in_valid is also 1 that cycle (back-to-back), latch the new op and go EXEC; otherwise out_valid<=0 and go IDLE.
- Illegal mode:
  - Not rejected; executed as given. The ALU returns 0 for non-one-hot modes.
  - out_illegal=1 travels with the result.
  - Illegal ops still count as retired.
- flush (priority below reset, above everything else):
  - At the next edge: state=IDLE; out_valid=0; counter=0.
  - The held op is dropped and retired_cnt is not incremented, even if out_ready=1 that cycle.
  - in_ready=0 during the flush cycle, so no op is accepted then.
  - Holding registers are kept.
- busy=1 in EXEC and DONE.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready only.

Test Plan:
- Reset with rst_n=0 for 2 cycles, inputs random -> out_valid=0, in_ready=0 during reset, retired_cnt=0. After release: in_ready=1, busy=0.
- LATENCY=3, accept src1=5, src2=7, mode=0 (add), rd=3, wen=1 with out_ready=1, ALU model attached -> out_valid rises exactly 3 cycles after accept edge. out_data=12, out_rd=3, retired_cnt=1.
- Backpressure: out_ready=0 for 5 cycles after result, sub 10-3 (mode=0x002) -> out_data=7 and out_valid held stable all 5 cycles. in_ready=0 throughout.
- Back-to-back, LATENCY=1: in_valid continuously high with 4 ops, out_ready=1 -> one retirement every 2 cycles. retired_cnt=4, no op lost or duplicated.
- Flush in EXEC, then flush in DONE with out_ready=1 -> both ops dropped, out_valid=0 next cycle, retired_cnt unchanged, state IDLE.
- Mode 0x006 (two op bits set) -> out_illegal=1, out_data=0, op retires. A following legal op has out_illegal=0.
